// File: rtl/eio_bus_ctrl.sv
// eio_bus_ctrl: sequences one RisKy1 EIO access at a time onto N_DEV
// memory-mapped device slots, with decode and timeout fault completion.
//
// Ports:
//   clk_in, reset_in          clock, async active-high reset
//   cpu_req/rd/wr/addr/wr_data  core access request, held until cpu_ack
//   cpu_ack/ack_fault/ack_data  one-cycle registered completion
//   dev_req                   one-hot request to the decoded slot
//   dev_rd/wr/addr/wr_data    latched access fields, shared by all slots
//   dev_ack, dev_ack_data     per-slot done strobe and read data
module eio_bus_ctrl #(
    parameter int unsigned N_DEV    = 4,
    parameter logic [31:0] EIO_BASE = 32'hFFFF_0000,
    parameter int unsigned SEL_LSB  = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  cpu_req,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wr_data,
    output logic                  cpu_ack,
    output logic                  cpu_ack_fault,
    output logic [31:0]           cpu_ack_data,
    output logic [N_DEV-1:0]      dev_req,
    output logic                  dev_rd,
    output logic                  dev_wr,
    output logic [SEL_LSB-1:0]    dev_addr,
    output logic [31:0]           dev_wr_data,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [32*N_DEV-1:0]   dev_ack_data
);

    localparam int unsigned SW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    // Window size in bytes; 33 bits so a full 4 GiB window still compares.
    localparam logic [32:0]   WIN      = 33'(N_DEV) << SEL_LSB;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t               state_q, state_d;
    logic [N_DEV-1:0]     req_q, req_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic [SEL_LSB-1:0]   addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 fault_q, fault_d;
    logic [31:0]          data_q, data_d;

    // Decode of the incoming access; offset wraps so addresses below
    // the base land far outside the window.
    logic [31:0]   off;
    logic          bad;
    logic [SW-1:0] sel_in;
    logic          hit_ack;
    logic [31:0]   hit_data;

    assign off    = cpu_addr - EIO_BASE;
    assign bad    = ({1'b0, off} >= WIN)
                 || (cpu_addr[1:0] != 2'b00)
                 || (cpu_rd == cpu_wr);
    assign sel_in = off[SEL_LSB +: SW];

    assign hit_ack  = dev_ack[sel_q];
    assign hit_data = dev_ack_data[32*int'(sel_q) +: 32];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        fault_d = 1'b0;
        data_d  = 32'h0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    rd_d    = cpu_rd;
                    wr_d    = cpu_wr;
                    wdata_d = cpu_wr_data;
                    addr_d  = off[SEL_LSB-1:0];
                    sel_d   = sel_in;
                    if (bad) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        req_d   = N_DEV'(1) << sel_in;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Device ack takes priority over a coincident timeout.
                if (hit_ack) begin
                    state_d = S_ACK;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    data_d  = rd_q ? hit_data : 32'h0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ACK;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    fault_d = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
            data_q  <= data_d;
        end
    end

    assign cpu_ack       = ack_q;
    assign cpu_ack_fault = fault_q;
    assign cpu_ack_data  = data_q;
    assign dev_req       = req_q;
    assign dev_rd        = rd_q;
    assign dev_wr        = wr_q;
    assign dev_addr      = addr_q;
    assign dev_wr_data   = wdata_q;

endmodule

// File: doc/eio_bus_ctrl.md
# eio_bus_ctrl

Sequencing controller between the RisKy1 core's External I/O port and up to N_DEV memory-mapped external devices. The block accepts one CPU EIO access at a time and decodes its address to a device slot. It then drives that device's request until the device acknowledges, and returns a single-cycle acknowledge with read data to the core. Accesses that are undecodable, misaligned, malformed or unanswered within a timeout complete with a fault acknowledge, so the core never hangs on the EIO path.

## Interface
- N_DEV, 4, number of device slots (1..16)
- EIO_BASE, 32'hFFFF_0000, byte base address of the EIO window; aligned to N_DEV<<SEL_LSB
- SEL_LSB, 8, log2 of bytes per device slot
- TIMEOUT, 255, cycles in WAIT before a fault completion (>=1)

Ports:
- clk_in  in  1  clock
- reset_in  in  1  reset, asynchronous, active-high
- cpu_req  in  1  access request; held, with all cpu_* fields stable, until cpu_ack; low in the cycle after cpu_ack
- cpu_rd  in  1  read access
- cpu_wr  in  1  write access
- cpu_addr  in  32  byte address
- cpu_wr_data  in  32  write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_ack_fault  out  1  qualifies cpu_ack: access faulted
- cpu_ack_data  out  32  read data, valid with cpu_ack; 0 on faults and writes
- dev_req  out  N_DEV  one-hot request to the selected device
- dev_rd, dev_wr  out  1 each  latched access type, shared by all devices
- dev_addr  out  SEL_LSB  byte offset within the slot
- dev_wr_data  out  32  latched write data
- dev_ack  in  N_DEV  device done, sampled only for the selected slot
- dev_ack_data  in  32*N_DEV  slot i read data in bits [32*i+31:32*i]

## Operation
- States: IDLE, WAIT, ACK. All registers and outputs reset to 0 and the state to IDLE, asynchronously and immediately, including mid-access.
- IDLE, cpu_req=1 at edge: compute off = cpu_addr - EIO_BASE (32-bit, wraps) and latch rd, wr, wr_data, sel = off>>SEL_LSB, and dev_addr = off[SEL_LSB-1:0].
  - Fault if any of: off >= N_DEV<<SEL_LSB; cpu_addr[1:0]!=0; rd==wr. Go to ACK with fault=1 and do not assert dev_req.
  - Otherwise go to WAIT, set dev_req[sel]=1 and clear the timeout counter.
- WAIT: dev_req[sel] is held. Each cycle the counter increments and saturates at TIMEOUT.
  - dev_ack[sel]=1 at edge: clear dev_req, capture cpu_ack_data (slot sel data if rd, else 0), go to ACK with fault=0.
  - Otherwise, counter == TIMEOUT-1 at edge: clear dev_req, go to ACK with fault=1 and data 0.
  - If dev_ack and the timeout condition occur at the same edge, the ack wins.
  - dev_ack on non-selected slots is ignored in every state.
- ACK: cpu_ack=1 for exactly one cycle, with cpu_ack_fault and cpu_ack_data valid. Next state is IDLE, where cpu_req is then low by protocol.
- cpu_ack, cpu_ack_fault and cpu_ack_data are 0 outside ACK.
- dev_rd, dev_wr, dev_addr and dev_wr_data hold their latched values until the next accepted access.
- Counter width is $clog2(TIMEOUT+1).

## Timing
- Edge numbering: E0 is the IDLE edge that samples cpu_req.
- Decode hit: dev_req high from E0 until the edge that samples dev_ack.
  - A device acking combinationally in its first request cycle gives cpu_ack in the cycle after E1, i.e. 2-cycle latency.
  - General case: device ack sampled at edge Ek gives cpu_ack in the cycle after Ek.
- Decode fault: cpu_ack with fault in the cycle after E0 (1 cycle); dev_req never rises.
- Timeout: dev_req high for exactly TIMEOUT cycles, then the fault ack cycle.
- Throughput: one access per (latency + 1) cycles, because IDLE must see the dropped cpu_req for one cycle.
- Outputs are registered; no combinational path from cpu_* or dev_* inputs to any output.

## Test plan
- Read, slot 2, device acks 3 cycles after dev_req rises with data 32'h1234_5678:
  - dev_req = 4'b0100 and dev_addr = 8'h10 for cpu_addr 32'hFFFF_0210.
  - cpu_ack=1, fault=0, data 32'h1234_5678, exactly 4 cycles after E0.
- Write 32'hCAFE_F00D to 32'hFFFF_0004, device 0 acks immediately:
  - dev_wr=1 and dev_wr_data correct.
  - cpu_ack at 2-cycle latency, cpu_ack_data=0.
- Decode faults each give a 1-cycle ack with fault=1 and dev_req staying 0: cpu_addr 32'hFFFF_0400 (out of window, N_DEV=4); 32'hFFFF_0101 (misaligned); rd=wr=1; 32'h0000_0000 (below base, wraps).
- Slot 1 never acks, TIMEOUT=255:
  - dev_req[1] high for exactly 255 cycles, then cpu_ack with fault=1.
  - A stray dev_ack[3] pulse during WAIT is ignored.
- dev_ack[sel] asserted on the same edge as the timeout: completes with fault=0 and the device data.
- reset_in pulsed mid-WAIT: all outputs 0 immediately, state IDLE; a new read after reset completes normally.
